// File: rtl/lsu_pkg.sv
// lsu_pkg: Funct3 encodings, FSM states and the access-legality check shared by the load/store unit.
package lsu_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic legal;
      legal = we ? (f3 == SB || f3 == SH || f3 == SW)
                 : (f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU);
      return !legal || ((f3 == LH || f3 == LHU) && a[0]) || (f3 == LW && a != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: store byte-enable/lane replication and load lane extract with sign/zero extension.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  f3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel  = addr_lo[1] ? (addr_lo[0] ? load_word[31:24] : load_word[23:16])
                             : (addr_lo[0] ? load_word[15:8]  : load_word[7:0]);
      half_sel  = addr_lo[1] ? load_word[31:16] : load_word[15:0];
      be        = (f3[1:0] == 2'b00) ? 4'b0001 << addr_lo
                : (f3[1:0] == 2'b01) ? (addr_lo[1] ? 4'b1100 : 4'b0011)
                : 4'b1111;
      wdata     = (f3[1:0] == 2'b00) ? {4{store_data[7:0]}}
                : (f3[1:0] == 2'b01) ? {2{store_data[15:0]}}
                : store_data;
      // f3[2] marks the unsigned load variants
      load_data = (f3[1:0] == 2'b00) ? {{24{~f3[2] & byte_sel[7]}}, byte_sel}
                : (f3[1:0] == 2'b01) ? {{16{~f3[2] & half_sel[15]}}, half_sel}
                : load_word;
   end

endmodule

// File: rtl/lsu_2.sv
// lsu_2: load/store unit driving a req/gnt/rvalid data-memory port; stalls the core while an access is in flight.
module lsu_2
   import lsu_pkg::*;
#(
   parameter int P = 32
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         Start,
   input  logic         MemRead,
   input  logic         MemWrite,
   input  logic [2:0]   Funct3,
   input  logic [P-1:0] ALUResult,
   input  logic [P-1:0] WriteData,
   output logic [P-1:0] ReadData,
   output logic         Stall,
   output logic         Done,
   output logic         Fault,
   output logic         mem_req,
   output logic         mem_we,
   output logic [P-1:0] mem_addr,
   output logic [3:0]   mem_be,
   output logic [P-1:0] mem_wdata,
   input  logic         mem_gnt,
   input  logic         mem_rvalid,
   input  logic [P-1:0] mem_rdata
);

   state_t       state_q, state_d;
   logic [P-1:0] addr_q, addr_d;
   logic [P-1:0] data_q, data_d;
   logic [2:0]   f3_q, f3_d;
   logic         we_q, we_d;
   logic         fault_q, fault_d;
   logic [P-1:0] rdata_q, rdata_d;
   logic         accept;
   logic         bad;
   logic [3:0]   lane_be;
   logic [P-1:0] lane_wdata;
   logic [P-1:0] lane_load;

   lsu_lane u_lane (
      .f3         (f3_q),
      .addr_lo    (addr_q[1:0]),
      .store_data (data_q),
      .load_word  (mem_rdata),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .load_data  (lane_load)
   );

   always_comb begin
      accept  = Start & (MemRead | MemWrite);
      bad     = is_fault(MemWrite, Funct3, ALUResult[1:0]);
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      f3_d    = f3_q;
      we_d    = we_q;
      fault_d = fault_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: if (accept) begin
            addr_d  = ALUResult;
            data_d  = WriteData;
            f3_d    = Funct3;
            we_d    = MemWrite;
            fault_d = bad;
            state_d = bad ? DONE : REQ;
         end
         REQ:  if (mem_gnt) state_d = we_q ? DONE : WAIT;
         WAIT: if (mem_rvalid) begin
            rdata_d = lane_load;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory-side outputs are only driven while a request is on the bus
   always_comb begin
      mem_req   = state_q == REQ;
      mem_we    = mem_req & we_q;
      mem_addr  = mem_req ? {addr_q[P-1:2], 2'b00} : '0;
      mem_be    = mem_req ? lane_be : 4'b0000;
      mem_wdata = mem_req ? lane_wdata : '0;
      Stall     = ((state_q == IDLE) & accept) | (state_q == REQ) | (state_q == WAIT);
      Done      = state_q == DONE;
      Fault     = fault_q;
      ReadData  = rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         f3_q    <= 3'b000;
         we_q    <= 1'b0;
         fault_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_2.sv
// tb_lsu_2: directed load/store transactions checked every cycle against a transaction-level model.
module tb_lsu_2;

   logic        clk = 1'b0;
   logic        reset, Start, MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] ALUResult, WriteData, ReadData, mem_addr, mem_wdata, mem_rdata;
   logic        Stall, Done, Fault, mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [3:0]  mem_be;

   lsu_2 #(.P(32)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
      .Stall(Stall), .Done(Done), .Fault(Fault), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fault;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] ld;
   } exp_t;

   int errors = 0;
   int checks = 0;

   logic        chk_on = 1'b0;
   logic        e_stall, e_done, e_req, e_we, e_fault, e_fault_on, e_rd_on, rd_known;
   logic [31:0] e_addr, e_wdata, e_rd;
   logic [3:0]  e_be;

   function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd);
      exp_t m;
      int sz, lane;
      logic legal;
      logic [31:0] v, mask;
      sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      lane  = int'(a[1:0]);
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      m.fault = !legal || (lane % sz != 0);
      m.addr  = a & ~32'd3;
      m.be    = 4'(((1 << sz) - 1) << lane);
      m.wdata = sz == 1 ? {24'd0, wd[7:0]} * 32'h01010101
              : sz == 2 ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
      mask = sz == 4 ? 32'hFFFFFFFF : (32'd1 << (8 * sz)) - 32'd1;
      v    = (rd >> (8 * lane)) & mask;
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
      m.ld = v;
      return m;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("stall", 32'(Stall), 32'(e_stall));
         chk("done", 32'(Done), 32'(e_done));
         chk("mem_req", 32'(mem_req), 32'(e_req));
         if (e_req) begin
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_we) begin
               chk("mem_be", 32'(mem_be), 32'(e_be));
               chk("mem_wdata", mem_wdata, e_wdata);
            end
         end
         if (e_fault_on) chk("fault", 32'(Fault), 32'(e_fault));
         if (e_rd_on) chk("read_data", ReadData, e_rd);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // gd: cycles without grant in REQ; vd: cycles without rvalid in WAIT
   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int gd, input int vd);
      exp_t m;
      m = model(we, f3, a, wd, rdat);
      Start = 1'b1; MemWrite = we; MemRead = !we; Funct3 = f3; ALUResult = a; WriteData = wd;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      e_stall = 1'b1; e_done = 1'b0; e_req = 1'b0; e_fault_on = 1'b0;
      e_rd_on = !we && rd_known;
      if (we || m.fault) rd_known = 1'b0;
      cyc();
      if (!m.fault) begin
         for (int i = 0; i <= gd; i++) begin
            e_req = 1'b1; e_addr = m.addr; e_be = m.be; e_wdata = m.wdata; e_we = we;
            mem_gnt = (i == gd); mem_rvalid = (i != gd); mem_rdata = ~rdat;
            cyc();
         end
         e_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (!we) begin
            for (int i = 0; i <= vd; i++) begin
               mem_rvalid = (i == vd); mem_gnt = (i != vd); mem_rdata = (i == vd) ? rdat : ~rdat;
               cyc();
            end
            mem_rvalid = 1'b0; mem_gnt = 1'b0;
         end
      end
      e_stall = 1'b0; e_done = 1'b1; e_fault_on = 1'b1; e_fault = m.fault;
      if (!we && !m.fault) begin
         e_rd = m.ld; e_rd_on = 1'b1; rd_known = 1'b1;
      end else e_rd_on = 1'b0;
      cyc();
      Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      e_done = 1'b0; e_stall = 1'b0;
   endtask

   initial begin
      exp_t m;
      m = model(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF0000);
      chk("pin_lb", m.ld, 32'hFFFFFF80);
      m = model(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF0000);
      chk("pin_lbu", m.ld, 32'h00000080);
      m = model(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0);
      chk("pin_sh_be", 32'(m.be), 32'hC);
      chk("pin_sh_wdata", m.wdata, 32'hABCDABCD);
      m = model(1'b0, 3'b101, 32'h12, 32'h0, 32'hABCD1234);
      chk("pin_lhu", m.ld, 32'h0000ABCD);
      m = model(1'b0, 3'b010, 32'h102, 32'h0, 32'h0);
      chk("pin_lw_fault", 32'(m.fault), 32'h1);

      reset = 1'b1; Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
      ALUResult = '0; WriteData = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      cyc();
      cyc();
      reset = 1'b0;
      chk("rst_read_data", ReadData, 32'h0);
      chk("rst_fault", 32'(Fault), 32'h0);
      chk("rst_done", 32'(Done), 32'h0);
      chk("rst_stall", 32'(Stall), 32'h0);
      chk("rst_req", 32'(mem_req), 32'h0);
      chk("rst_mem_out", {mem_addr[31:5], mem_be, mem_we} | mem_wdata, 32'h0);
      e_stall = 1'b0; e_done = 1'b0; e_req = 1'b0; e_fault_on = 1'b1; e_fault = 1'b0;
      e_rd_on = 1'b1; e_rd = '0; rd_known = 1'b1; e_we = 1'b0;
      e_addr = '0; e_be = '0; e_wdata = '0;
      chk_on = 1'b1;
      cyc();

      do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
      do_op(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF0000, 1, 0);
      chk("lb_literal", ReadData, 32'hFFFFFF80);
      do_op(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF0000, 0, 1);
      chk("lbu_literal", ReadData, 32'h00000080);
      do_op(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 2, 0);
      do_op(1'b0, 3'b101, 32'h12, 32'h0, 32'hABCD1234, 0, 0);
      chk("lhu_literal", ReadData, 32'h0000ABCD);
      do_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);
      chk("lw_mis_literal", 32'(Fault), 32'h1);
      do_op(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0);
      do_op(1'b1, 3'b100, 32'h20, 32'h1, 32'h0, 0, 0);
      do_op(1'b1, 3'b001, 32'h13, 32'h1234, 32'h0, 0, 0);
      do_op(1'b0, 3'b001, 32'h2, 32'h0, 32'h80010000, 2, 2);
      chk("lh_literal", ReadData, 32'hFFFF8001);
      do_op(1'b1, 3'b000, 32'h7, 32'h00000055, 32'h0, 1, 0);
      do_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h11112222, 0, 0);
      do_op(1'b0, 3'b010, 32'h44, 32'h0, 32'h33334444, 0, 0);
      chk("b2b_literal", ReadData, 32'h33334444);
      cyc();

      m = model(1'b0, 3'b010, 32'h300, 32'h0, 32'h0);
      Start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h300;
      WriteData = '0; e_stall = 1'b1; e_fault_on = 1'b0; e_rd_on = 1'b1;
      cyc();
      e_req = 1'b1; e_addr = m.addr; e_we = 1'b0; mem_gnt = 1'b1;
      cyc();
      e_req = 1'b0; mem_gnt = 1'b0; reset = 1'b1;
      cyc();
      reset = 1'b0; Start = 1'b0; MemRead = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      e_stall = 1'b0; e_done = 1'b0; e_fault_on = 1'b1; e_fault = 1'b0;
      e_rd = '0; e_rd_on = 1'b1; rd_known = 1'b1;
      chk("abort_mem_out", {mem_addr[31:5], mem_be, mem_we} | mem_wdata, 32'h0);
      cyc();
      mem_rvalid = 1'b0;
      cyc();
      cyc();
      do_op(1'b0, 3'b000, 32'h301, 32'h0, 32'h00007F00, 0, 0);
      chk("post_reset_lb", ReadData, 32'h0000007F);
      cyc();

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
